tt_pfd: RTL and testbench



---
 rtl/tt_pll_pkg.sv | 18 +
 rtl/tt_sync.sv | 23 ++
 rtl/tt_pfd.sv | 176 +++++++++++++++++
 tb/tb_tt_pfd.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pll_pkg.sv
// Shared PLL types: PFD state encoding (also used by top-level debug) and scan-chain layout.
package tt_pll_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StUp   = 2'b01,
        StDown = 2'b10
    } pfd_state_e;

    localparam int unsigned PfdStateBits = 2;

    // Chain order from scan-in: state, wcnt, phase_err, lock_cnt (LSB first within each field).
    function automatic int unsigned pfd_scan_len(input int unsigned cnt_w,
                                                 input int unsigned lock_w);
        return PfdStateBits + 2 * cnt_w + lock_w;
    endfunction

endpackage

// File: rtl/tt_sync.sv
// N-flop synchronizer for one asynchronous bit; every stage resets to 0.
module tt_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/tt_pfd.sv
// Tri-state phase-frequency detector: synchronizes ref/fb, drives up/down pulses, reports
// signed phase error, cycle slips and lock. FSM and counters form one scan chain.
module tt_pfd
    import tt_pll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_WINDOW = 2,
    parameter int unsigned LOCK_COUNT  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ref,
    input  logic                    i_fb,
    output logic                    o_up,
    output logic                    o_down,
    output logic signed [CNT_W-1:0] o_phase_err,
    output logic                    o_err_valid,
    output logic                    o_slip,
    output logic                    o_locked,
    input  logic                    i_scan_en,
    input  logic                    i_scan_in,
    output logic                    o_scan_out
);

    localparam int unsigned LockW   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned ScanLen = pfd_scan_len(CNT_W, LockW);
    localparam int unsigned ErrOff  = PfdStateBits + CNT_W;
    localparam int unsigned LockOff = PfdStateBits + 2 * CNT_W;

    localparam logic [CNT_W-1:0] WcntMax   = {1'b0, {(CNT_W - 1){1'b1}}};
    localparam logic [CNT_W-1:0] WindowMax = CNT_W'(LOCK_WINDOW);
    localparam logic [LockW-1:0] LockMax   = LockW'(LOCK_COUNT);

    logic ref_s, fb_s;
    logic ref_h_q, fb_h_q;
    logic ref_rise, fb_rise;

    pfd_state_e              state_q, state_d;
    logic [CNT_W-1:0]        wcnt_q, wcnt_d, wcnt_inc, err_mag;
    logic signed [CNT_W-1:0] phase_err_q, phase_err_d;
    logic [LockW-1:0]        lock_cnt_q, lock_cnt_d;
    logic                    err_valid_q, err_valid_d;
    logic                    slip_q, slip_d;
    logic                    locked_q, locked_d;
    logic                    complete, slip;
    logic [ScanLen-1:0]      chain_q, chain_d;

    tt_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_ref (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d_i     (i_ref),
        .q_o     (ref_s)
    );

    tt_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_fb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d_i     (i_fb),
        .q_o     (fb_s)
    );

    assign ref_rise = ref_s & ~ref_h_q;
    assign fb_rise  = fb_s & ~fb_h_q;
    assign wcnt_inc = (wcnt_q == WcntMax) ? WcntMax : wcnt_q + CNT_W'(1);

    assign chain_q = {lock_cnt_q, phase_err_q, wcnt_q, state_q};
    assign chain_d = {chain_q[ScanLen-2:0], i_scan_in};

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        phase_err_d = phase_err_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        complete    = 1'b0;
        slip        = 1'b0;
        err_mag     = '0;
        if (i_scan_en) begin
            state_d     = pfd_state_e'(chain_d[PfdStateBits-1:0]);
            wcnt_d      = chain_d[PfdStateBits +: CNT_W];
            phase_err_d = $signed(chain_d[ErrOff +: CNT_W]);
            lock_cnt_d  = chain_d[LockOff +: LockW];
        end else begin
            locked_d = (lock_cnt_q == LockMax);
            case (state_q)
                StIdle: begin
                    if (ref_rise && fb_rise) begin
                        complete    = 1'b1;
                        phase_err_d = '0;
                    end else if (ref_rise) begin
                        state_d = StUp;
                        wcnt_d  = CNT_W'(1);
                    end else if (fb_rise) begin
                        state_d = StDown;
                        wcnt_d  = CNT_W'(1);
                    end
                end
                StUp: begin
                    // The lagging edge wins even when the leading input also rises again.
                    if (fb_rise) begin
                        state_d     = StIdle;
                        complete    = 1'b1;
                        err_mag     = wcnt_q;
                        phase_err_d = $signed(wcnt_q);
                    end else begin
                        wcnt_d = wcnt_inc;
                        slip   = ref_rise;
                    end
                end
                StDown: begin
                    if (ref_rise) begin
                        state_d     = StIdle;
                        complete    = 1'b1;
                        err_mag     = wcnt_q;
                        phase_err_d = -$signed(wcnt_q);
                    end else begin
                        wcnt_d = wcnt_inc;
                        slip   = fb_rise;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (slip) begin
                lock_cnt_d = '0;
            end else if (complete) begin
                if (err_mag <= WindowMax) begin
                    lock_cnt_d = (lock_cnt_q == LockMax) ? LockMax : lock_cnt_q + LockW'(1);
                end else begin
                    lock_cnt_d = '0;
                end
            end
        end
    end

    assign err_valid_d = complete;
    assign slip_d      = slip;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ref_h_q     <= 1'b0;
            fb_h_q      <= 1'b0;
            state_q     <= StIdle;
            wcnt_q      <= '0;
            phase_err_q <= '0;
            lock_cnt_q  <= '0;
            err_valid_q <= 1'b0;
            slip_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            ref_h_q     <= ref_s;
            fb_h_q      <= fb_s;
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            phase_err_q <= phase_err_d;
            lock_cnt_q  <= lock_cnt_d;
            err_valid_q <= err_valid_d;
            slip_q      <= slip_d;
            locked_q    <= locked_d;
        end
    end

    assign o_up        = (state_q == StUp);
    assign o_down      = (state_q == StDown);
    assign o_phase_err = phase_err_q;
    assign o_err_valid = err_valid_q;
    assign o_slip      = slip_q;
    assign o_locked    = locked_q;
    assign o_scan_out  = chain_q[ScanLen-1];

endmodule

// File: tb/tb_tt_pfd.sv
// Bench for tt_pfd: an edge-timestamp reference model compared every cycle, plus directed
// literal checks of widths, errors, lock, slip, scan shifting and asynchronous reset.
module tb_tt_pfd;

    localparam int S          = 2;
    localparam int CntW       = 8;
    localparam int LockWindow = 2;
    localparam int LockCount  = 16;
    localparam int LockW      = 5;
    localparam int ScanLen    = 2 + 2 * CntW + LockW;
    localparam int WMax       = (1 << (CntW - 1)) - 1;

    logic clk = 1'b0;
    logic rst_n, ref_in, fb_in, scan_en, scan_in;
    logic up, down, err_valid, slip, locked, scan_out;
    logic signed [CntW-1:0] phase_err;

    always #5 clk = ~clk;

    tt_pfd #(
        .SYNC_STAGES (S),
        .CNT_W       (CntW),
        .LOCK_WINDOW (LockWindow),
        .LOCK_COUNT  (LockCount)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ref       (ref_in),
        .i_fb        (fb_in),
        .o_up        (up),
        .o_down      (down),
        .o_phase_err (phase_err),
        .o_err_valid (err_valid),
        .o_slip      (slip),
        .o_locked    (locked),
        .i_scan_en   (scan_en),
        .i_scan_in   (scan_in),
        .o_scan_out  (scan_out)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: each input is sampled at every edge; a rise takes effect S edges later.
    // A pulse is the interval between the effective leading and lagging rises.
    bit r_hist [0:S];
    bit f_hist [0:S];
    bit r_eff, f_eff;
    int mode, start_e, lock_run, m_edge, m_err;
    bit m_up, m_down, m_valid, m_slip, m_locked;

    function automatic int sat(input int w);
        return (w > WMax) ? WMax : w;
    endfunction

    task automatic finish_cmp(input int err);
        m_err   = err;
        m_valid = 1'b1;
        if (err <= LockWindow && err >= -LockWindow)
            lock_run = (lock_run < LockCount) ? lock_run + 1 : LockCount;
        else
            lock_run = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= S; j++) begin
                r_hist[j] = 1'b0;
                f_hist[j] = 1'b0;
            end
            mode = 0; start_e = 0; lock_run = 0; m_edge = 0; m_err = 0;
            m_up = 0; m_down = 0; m_valid = 0; m_slip = 0; m_locked = 0;
        end else begin
            m_edge++;
            r_eff   = r_hist[S-1] && !r_hist[S];
            f_eff   = f_hist[S-1] && !f_hist[S];
            m_valid = 1'b0;
            m_slip  = 1'b0;
            if (!scan_en) begin
                m_locked = (lock_run == LockCount);
                if (mode == 0) begin
                    if (r_eff && f_eff) finish_cmp(0);
                    else if (r_eff) begin mode = 1; start_e = m_edge; end
                    else if (f_eff) begin mode = -1; start_e = m_edge; end
                end else if (mode == 1) begin
                    if (f_eff) begin finish_cmp(sat(m_edge - start_e)); mode = 0; end
                    else if (r_eff) begin m_slip = 1'b1; lock_run = 0; end
                end else begin
                    if (r_eff) begin finish_cmp(-sat(m_edge - start_e)); mode = 0; end
                    else if (f_eff) begin m_slip = 1'b1; lock_run = 0; end
                end
            end
            for (int j = S; j > 0; j--) begin
                r_hist[j] = r_hist[j-1];
                f_hist[j] = f_hist[j-1];
            end
            r_hist[0] = ref_in;
            f_hist[0] = fb_in;
            m_up   = (mode == 1);
            m_down = (mode == -1);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !scan_en) begin
            check("up", up, m_up);
            check("down", down, m_down);
            check("err_valid", err_valid, m_valid);
            check("slip", slip, m_slip);
            check("locked", locked, m_locked);
            check("phase_err", int'(phase_err), m_err);
        end
    end

    // Observation counters for the directed literal checks.
    int cyc = 0;
    int up_cnt, down_cnt, valid_cnt, slip_cnt, last_err, v16_cyc, lk_cyc;
    bit lk_seen;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (up) up_cnt++;
        if (down) down_cnt++;
        if (slip) slip_cnt++;
        if (err_valid) begin
            valid_cnt++;
            last_err = int'(phase_err);
            if (valid_cnt == 16) v16_cyc = cyc;
        end
        if (locked && !lk_seen) begin
            lk_seen = 1'b1;
            lk_cyc  = cyc;
        end
    end

    task automatic clear_mon();
        up_cnt = 0; down_cnt = 0; valid_cnt = 0; slip_cnt = 0; last_err = 0;
        v16_cyc = 0; lk_cyc = 0; lk_seen = 1'b0;
    endtask

    task automatic cycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    // d > 0: ref leads by d cycles; d < 0: fb leads by -d; d == 0: coincident.
    task automatic edge_pair(input int d);
        if (d >= 0) begin
            ref_in = 1'b1; cycles(d); fb_in = 1'b1;
        end else begin
            fb_in = 1'b1; cycles(-d); ref_in = 1'b1;
        end
        cycles(4);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        cycles(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v;
        logic [ScanLen-1:0] pre;
        logic [31:0] pat, got;

        rst_n = 1'b0; ref_in = 1'b0; fb_in = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        clear_mon();
        cycles(3);
        check("rst_up", up, 0);
        check("rst_down", down, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_slip", slip, 0);
        check("rst_locked", locked, 0);
        check("rst_phase_err", int'(phase_err), 0);
        check("rst_scan_out", scan_out, 0);

        rst_n = 1'b1; chk_en = 1'b1; clear_mon();
        cycles(100);
        check("idle_valid_cnt", valid_cnt, 0);
        check("idle_slip_cnt", slip_cnt, 0);
        check("idle_up_cnt", up_cnt + down_cnt, 0);

        clear_mon(); edge_pair(5);
        check("lead5_up_cnt", up_cnt, 5);
        check("lead5_down_cnt", down_cnt, 0);
        check("lead5_valid_cnt", valid_cnt, 1);
        check("lead5_err", last_err, 5);

        clear_mon(); edge_pair(-3);
        check("lag3_down_cnt", down_cnt, 3);
        check("lag3_up_cnt", up_cnt, 0);
        check("lag3_valid_cnt", valid_cnt, 1);
        check("lag3_err", last_err, -3);

        clear_mon(); edge_pair(0);
        check("coinc_pulse_cnt", up_cnt + down_cnt, 0);
        check("coinc_valid_cnt", valid_cnt, 1);
        check("coinc_err", last_err, 0);

        rst_n = 1'b0; cycles(2); rst_n = 1'b1; clear_mon();
        repeat (16) edge_pair(0);
        check("lock_valid_cnt", valid_cnt, 16);
        check("lock_seen", lk_seen, 1);
        check("lock_delay", lk_cyc - v16_cyc, 1);
        check("lock_level", locked, 1);

        clear_mon(); edge_pair(6);
        check("unlock_level", locked, 0);
        check("unlock_err", last_err, 6);
        check("unlock_up_cnt", up_cnt, 6);

        chk_en = 1'b0; scan_en = 1'b1;
        v = 0;
        for (int i = 0; i < LockW; i++) begin
            @(negedge clk); v = (v << 1) | int'(scan_out);
            @(posedge clk); #2;
        end
        check("scan_lock_cnt", v, 0);
        v = 0;
        for (int i = 0; i < CntW; i++) begin
            @(negedge clk); v = (v << 1) | int'(scan_out);
            @(posedge clk); #2;
        end
        check("scan_phase_err", v, 6);

        // Preload UP with wcnt=10, then close the pulse with an fb edge.
        pre = {5'd0, 8'd0, 8'd10, 2'b01};
        for (int i = ScanLen - 1; i >= 0; i--) begin
            scan_in = pre[i];
            cycles(1);
        end
        scan_in = 1'b0; scan_en = 1'b0; clear_mon();
        fb_in = 1'b1;
        @(negedge clk);
        check("preload_up", up, 1);
        check("preload_down", down, 0);
        cycles(6);
        fb_in = 1'b0;
        check("preload_valid_cnt", valid_cnt, 1);
        check("preload_err", last_err, 12);
        check("preload_up_after", up, 0);
        cycles(4);

        pat = 32'hA5C3_0F96; got = '0;
        scan_en = 1'b1;
        for (int t = 0; t < 32 + ScanLen; t++) begin
            scan_in = (t < 32) ? pat[t] : 1'b0;
            @(negedge clk);
            if (t >= ScanLen) got[t-ScanLen] = scan_out;
            @(posedge clk); #2;
        end
        check("scan_pattern", int'(got), int'(pat));
        scan_en = 1'b0; scan_in = 1'b0;

        rst_n = 1'b0; cycles(2); rst_n = 1'b1; chk_en = 1'b1; clear_mon();
        ref_in = 1'b1; cycles(4); ref_in = 1'b0; cycles(296);
        ref_in = 1'b1; cycles(4); ref_in = 1'b0; cycles(16);
        fb_in = 1'b1; cycles(4); fb_in = 1'b0; cycles(6);
        check("slip_cnt", slip_cnt, 1);
        check("slip_up_cnt", up_cnt, 320);
        check("slip_down_cnt", down_cnt, 0);
        check("slip_valid_cnt", valid_cnt, 1);
        check("slip_err", last_err, 127);

        ref_in = 1'b1; cycles(5);
        check("pre_rst_up", up, 1);
        #1 rst_n = 1'b0;
        #1 check("async_rst_up", up, 0);
        ref_in = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        check("post_rst_up", up, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
